// File: rtl/mac_block_reader.sv
// Consumer end of the MAC block-read interface: requests a block, captures the unstallable
// result stream into a FIFO and replays it on valid/ready. Option: MAC_BLOCK_READER_CHECKSUM_EN.
module mac_block_reader #(
  parameter int BLOCK_WORDS  = 64,
  parameter int FIFO_DEPTH   = 16,
  parameter int WAIT_TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN_start,
  output logic        RDY_start,
  input  logic        RDY_blockRead,
  output logic        EN_blockRead,
  input  logic        VALID_memVal,
  input  logic [31:0] memVal_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        overflow,
  output logic        timeout
`ifdef MAC_BLOCK_READER_CHECKSUM_EN
  ,
  output logic [31:0] checksum,
  output logic        checksum_valid
`endif
);

  localparam int CNT_W  = $clog2(BLOCK_WORDS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  word_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [OCC_W-1:0]  occ, remain;
  logic [31:0]       head_next;

  logic start_acc, push_req, push, pop, drop;
  logic fifo_full, fifo_empty, last_word, wait_expired;

  assign start_acc    = (state == S_IDLE) && EN_start;
  assign push_req     = ((state == S_WAIT) || (state == S_CAPTURE)) && VALID_memVal;
  assign fifo_full    = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty   = (occ == '0);
  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the word.
  assign push         = push_req && (!fifo_full || pop);
  assign drop         = push_req && fifo_full && !pop;
  assign last_word    = (word_cnt == CNT_W'(BLOCK_WORDS - 1));
  assign wait_expired = (wait_cnt == WAIT_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    RDY_start    = 1'b0;
    EN_blockRead = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        RDY_start = 1'b1;
        if (EN_start) state_next = S_REQ;
      end
      S_REQ: begin
        if (RDY_blockRead) begin
          EN_blockRead = 1'b1;
          state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (VALID_memVal)      state_next = last_word ? S_DRAIN : S_CAPTURE;
        else if (wait_expired) state_next = S_IDLE;
      end
      S_CAPTURE: begin
        if (VALID_memVal && last_word) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_cnt <= '0;
      wait_cnt <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (start_acc) begin
        word_cnt <= '0;
        overflow <= 1'b0;
        timeout  <= 1'b0;
      end else begin
        if (push_req) word_cnt <= word_cnt + CNT_W'(1);
        if (drop) overflow <= 1'b1;
        if ((state == S_WAIT) && !VALID_memVal && wait_expired) timeout <= 1'b1;
      end
      if (state == S_REQ)
        wait_cnt <= '0;
      else if ((state == S_WAIT) && !VALID_memVal)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Next head word: the word being pushed when it lands in an emptied FIFO, else storage.
  always_comb begin
    rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    remain    = occ - OCC_W'(pop);
    head_next = out_data;
    if (push && (remain == '0))
      head_next = memVal_data;
    else if (remain != '0)
      head_next = mem[rd_next];
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= memVal_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      out_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_next;
      occ      <= occ + OCC_W'(push) - OCC_W'(pop);
      out_data <= head_next;
    end
  end

`ifdef MAC_BLOCK_READER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Dropped words still count: the sum covers everything the MAC streamed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (push_req)  sum_q <= sum_q + memVal_data;
  end

  assign checksum       = sum_q;
  assign checksum_valid = done;
`endif

endmodule

// File: tb/tb_mac_block_reader.sv
// Directed self-checking bench for mac_block_reader: streaming, overflow, gaps,
// timeout, mid-block reset and (with MAC_BLOCK_READER_CHECKSUM_EN) the checksum.
module tb_mac_block_reader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN_start = 1'b0;
  logic        RDY_blockRead = 1'b0;
  logic        VALID_memVal = 1'b0;
  logic [31:0] memVal_data = '0;
  logic        out_ready = 1'b0;
  logic        RDY_start, EN_blockRead, out_valid, done, overflow, timeout;
  logic [31:0] out_data;
`ifdef MAC_BLOCK_READER_CHECKSUM_EN
  logic [31:0] checksum;
  logic        checksum_valid;
  logic [31:0] csum_seen = '0;
  int          csum_cnt = 0;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          en_cnt = 0;
  logic [31:0] got[$];

  always #5 CLK = ~CLK;

  mac_block_reader dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_start(EN_start), .RDY_start(RDY_start),
    .RDY_blockRead(RDY_blockRead), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .overflow(overflow), .timeout(timeout)
`ifdef MAC_BLOCK_READER_CHECKSUM_EN
    , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
  );

  // Observes handshakes mid-cycle; inputs only change just after rising edges.
  always @(negedge CLK) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
    if (EN_blockRead) en_cnt++;
`ifdef MAC_BLOCK_READER_CHECKSUM_EN
    if (checksum_valid) begin
      csum_seen = checksum;
      csum_cnt++;
    end
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge CLK); #1;
    EN_start = 1'b1;
    @(posedge CLK); #1;
    EN_start = 1'b0;
  endtask

  task automatic wait_en(input int base);
    int n = 0;
    while (en_cnt == base && n < 50) begin
      @(negedge CLK); #1;
      n++;
    end
    checkOutput("en_pulse_seen", 32'(en_cnt != base), 32'd1);
  endtask

  task automatic stream_words(input int gap_every, input bit ones, input bit rand_rdy);
    int idx = 0;
    int cyc = 0;
    logic [31:0] first;
    first = ones ? 32'hFFFF_FFFF : 32'd0;
    while (idx < 64) begin
      @(posedge CLK); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      if (gap_every != 0 && (cyc % gap_every) == gap_every - 1) begin
        VALID_memVal = 1'b0;
      end else begin
        VALID_memVal = 1'b1;
        memVal_data  = ones ? 32'hFFFF_FFFF : 32'(idx);
        idx++;
      end
      @(negedge CLK);
      if (cyc == 0) checkOutput("valid_before_latency", 32'(out_valid), 32'd0);
      if (cyc == 1) begin
        checkOutput("valid_after_latency", 32'(out_valid), 32'd1);
        checkOutput("head_after_latency", out_data, first);
      end
      if (idx == 10) checkOutput("rdy_start_busy", 32'(RDY_start), 32'd0);
      cyc++;
    end
    @(posedge CLK); #1;
    VALID_memVal = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input bit rand_rdy);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge CLK); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    checkOutput("done_seen", 32'(done_cnt != base), 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("done_once", 32'(done_cnt - base), 32'd1);
  endtask

  initial begin
    int base_got, base_done, base_en;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_rdy_start", 32'(RDY_start), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_en_blockread", 32'(EN_blockRead), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    RST_N = 1'b1;

    // Full block, sink always ready
    $display("[TB] block with ready sink");
    base_got = got.size(); base_done = done_cnt; base_en = en_cnt;
    RDY_blockRead = 1'b1; out_ready = 1'b1;
    applyStimulus();
    checkOutput("rdy_start_after_start", 32'(RDY_start), 32'd0);
    wait_en(base_en);
    repeat (2) @(posedge CLK);
    stream_words(0, 1'b0, 1'b0);
    wait_done(base_done, 200, 1'b0);
    checkOutput("t2_count", 32'(got.size() - base_got), 32'd64);
    for (int i = 0; i < 64 && base_got + i < got.size(); i++)
      checkOutput("t2_word", got[base_got + i], 32'(i));
    checkOutput("t2_en_pulses", 32'(en_cnt - base_en), 32'd1);
    checkOutput("t2_overflow", 32'(overflow), 32'd0);
    checkOutput("t2_rdy_start", 32'(RDY_start), 32'd1);

    // Stalled sink: only the first FIFO_DEPTH words survive
    $display("[TB] block with stalled sink");
    base_got = got.size(); base_done = done_cnt; base_en = en_cnt;
    out_ready = 1'b0;
    applyStimulus();
    wait_en(base_en);
    repeat (2) @(posedge CLK);
    stream_words(0, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("t3_overflow_set", 32'(overflow), 32'd1);
    checkOutput("t3_no_done_yet", 32'(done_cnt - base_done), 32'd0);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    wait_done(base_done, 200, 1'b0);
    checkOutput("t3_count", 32'(got.size() - base_got), 32'd16);
    for (int i = 0; i < 16 && base_got + i < got.size(); i++)
      checkOutput("t3_word", got[base_got + i], 32'(i));
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Late RDY_blockRead, gapped stream, random sink
    $display("[TB] gapped stream with random sink");
    base_got = got.size(); base_done = done_cnt; base_en = en_cnt;
    RDY_blockRead = 1'b0;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("t4_no_req_until_ready", 32'(EN_blockRead), 32'd0);
    end
    checkOutput("t4_overflow_cleared", 32'(overflow), 32'd0);
    @(posedge CLK); #1;
    RDY_blockRead = 1'b1;
    wait_en(base_en);
    repeat (2) @(posedge CLK);
    stream_words(3, 1'b0, 1'b1);
    wait_done(base_done, 1000, 1'b1);
    checkOutput("t4_count", 32'(got.size() - base_got), 32'd64);
    for (int i = 0; i < 64 && base_got + i < got.size(); i++)
      checkOutput("t4_word", got[base_got + i], 32'(i));
    checkOutput("t4_overflow", 32'(overflow), 32'd0);

    // No response from the MAC: timeout after 256 waiting cycles
    $display("[TB] timeout");
    base_done = done_cnt;
    @(posedge CLK); #1;
    EN_start = 1'b1;
    @(posedge CLK); #1;
    EN_start = 1'b0;
    @(negedge CLK);
    checkOutput("t5_req_pulse", 32'(EN_blockRead), 32'd1);
    repeat (256) @(negedge CLK);
    checkOutput("t5_timeout_not_early", 32'(timeout), 32'd0);
    @(negedge CLK);
    checkOutput("t5_timeout_set", 32'(timeout), 32'd1);
    checkOutput("t5_back_idle", 32'(RDY_start), 32'd1);
    repeat (3) @(negedge CLK);
    checkOutput("t5_no_done", 32'(done_cnt - base_done), 32'd0);

`ifdef MAC_BLOCK_READER_CHECKSUM_EN
    // All-ones block: 64 * 0xFFFFFFFF mod 2^32
    $display("[TB] checksum");
    base_done = done_cnt; base_en = en_cnt;
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("t6_timeout_cleared", 32'(timeout), 32'd0);
    wait_en(base_en);
    repeat (2) @(posedge CLK);
    stream_words(0, 1'b1, 1'b0);
    wait_done(base_done, 200, 1'b0);
    checkOutput("t6_checksum", csum_seen, 32'hFFFF_FFC0);
    checkOutput("t6_checksum_valid_once", 32'(csum_cnt), 32'd1);
`endif

    // Reset mid-block flushes FIFO without a done pulse
    $display("[TB] reset mid-block");
    base_done = done_cnt; base_en = en_cnt;
    out_ready = 1'b0;
    applyStimulus();
    wait_en(base_en);
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      VALID_memVal = 1'b1;
      memVal_data  = 32'(100 + i);
    end
    @(posedge CLK); #1;
    VALID_memVal = 1'b0;
    checkOutput("t7_fifo_filled", 32'(out_valid), 32'd1);
    checkOutput("t7_head", out_data, 32'd100);
    RST_N = 1'b0;
    #1;
    checkOutput("t7_flushed", 32'(out_valid), 32'd0);
    checkOutput("t7_idle", 32'(RDY_start), 32'd1);
    repeat (3) @(negedge CLK);
    checkOutput("t7_no_done", 32'(done_cnt - base_done), 32'd0);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
